// File: rtl/lut_sweep_pkg.sv
// Shared types for the truth-table sweep checker.
// FSM encodings and settle-counter sizing.
package lut_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // clog2(settle+1), never narrower than one bit
   function automatic int settle_w(input int settle);
      return (settle < 1) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/lut_sweep_checker_settle.sv
// Settle timer: strobes once every SETTLE+1 enabled cycles.
// Collapses to a pass-through of en when SETTLE is zero.
module settle_timer
   import lut_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic strobe
);

   localparam int CW = settle_w(SETTLE);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= RELOAD;
      end else if (en) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
      end
   end

   assign strobe = en && (cnt == '0);

endmodule

// File: rtl/lut_sweep_checker.sv
// On-chip truth-table checker: sweeps all minterms into the
// function under test and compares against a serial-loaded mask.
module lut_sweep_checker
   import lut_sweep_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   input  logic            start,
   input  logic            dut_f,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail_idx,
   output logic            fail_seen,
   output logic [N_IN:0]   ones_cnt
);

   localparam int LUT_W = 2 ** N_IN;

   state_t           state;
   logic [LUT_W-1:0] mask;
   logic             start_acc;
   logic             sample;
   logic             miss;
   logic             last_vec;
   logic [N_IN:0]    mm_next;
   logic [N_IN:0]    ones_next;

   assign start_acc = (state == ST_IDLE) && start;
   assign miss      = dut_f != mask[stim];
   assign last_vec  = &stim;
   assign mm_next   = mismatch_cnt + (N_IN+1)'(miss);
   assign ones_next = ones_cnt + (N_IN+1)'(dut_f);

   settle_timer #(
      .SETTLE(SETTLE)
   ) u_settle (
      .clk   (clk),
      .rst   (rst),
      .load  (start_acc),
      .en    (state == ST_RUN),
      .strobe(sample)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         mask           <= '0;
         stim           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         fail_seen      <= 1'b0;
         ones_cnt       <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  mask <= {mask[LUT_W-2:0], cfg_bit};
               end
               if (start) begin
                  state          <= ST_RUN;
                  busy           <= 1'b1;
                  stim           <= '0;
                  pass           <= 1'b0;
                  mismatch_cnt   <= '0;
                  first_fail_idx <= '0;
                  fail_seen      <= 1'b0;
                  ones_cnt       <= '0;
               end
            end
            ST_RUN: begin
               if (sample) begin
                  mismatch_cnt <= mm_next;
                  ones_cnt     <= ones_next;
                  if (miss && !fail_seen) begin
                     first_fail_idx <= stim;
                     fail_seen      <= 1'b1;
                  end
                  if (last_vec) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (mm_next == '0);
                     stim  <= '0;
                  end else begin
                     stim <= stim + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench for lut_sweep_checker: 4-input SETTLE=1
// instance plus a 2-input SETTLE=0 instance.
module tb_lut_sweep_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_bit = 1'b0;
   logic       start = 1'b0;
   logic       dut_f;
   logic [3:0] stim;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] mismatch_cnt;
   logic [3:0] first_fail_idx;
   logic       fail_seen;
   logic [4:0] ones_cnt;

   logic       cfg_valid_b = 1'b0;
   logic       cfg_bit_b = 1'b0;
   logic       start_b = 1'b0;
   logic       dut_f_b;
   logic [1:0] stim_b;
   logic       busy_b;
   logic       done_b;
   logic       pass_b;
   logic [2:0] mismatch_cnt_b;
   logic [1:0] first_fail_idx_b;
   logic       fail_seen_b;
   logic [2:0] ones_cnt_b;

   int mode = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lut_sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_bit       (cfg_bit),
      .start         (start),
      .dut_f         (dut_f),
      .stim          (stim),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .mismatch_cnt  (mismatch_cnt),
      .first_fail_idx(first_fail_idx),
      .fail_seen     (fail_seen),
      .ones_cnt      (ones_cnt)
   );

   lut_sweep_checker #(.N_IN(2), .SETTLE(0)) u_dut_b (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid_b),
      .cfg_bit       (cfg_bit_b),
      .start         (start_b),
      .dut_f         (dut_f_b),
      .stim          (stim_b),
      .busy          (busy_b),
      .done          (done_b),
      .pass          (pass_b),
      .mismatch_cnt  (mismatch_cnt_b),
      .first_fail_idx(first_fail_idx_b),
      .fail_seen     (fail_seen_b),
      .ones_cnt      (ones_cnt_b)
   );

   // F = wx' + w'z' + y'z'
   function automatic logic golden(input logic [3:0] s);
      logic w, x, y, z;
      {w, x, y, z} = s;
      return (w & ~x) | (~w & ~z) | (~y & ~z);
   endfunction

   always_comb begin
      dut_f = 1'b0;
      case (mode)
         0: dut_f = golden(stim);
         1: dut_f = 1'b0;
         2: dut_f = golden(stim) ^ (stim == 4'd5);
         default: dut_f = 1'b0;
      endcase
   end

   assign dut_f_b = &stim_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic load_mask(input logic [15:0] m);
      for (int i = 15; i >= 0; i--) begin
         cfg_valid = 1'b1;
         cfg_bit   = m[i];
         tick();
      end
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   int n;
   int seen;

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_stim", stim, 0);
      check("rst_mm", mismatch_cnt, 0);
      check("rst_ones", ones_cnt, 0);
      check("rst_fseen", fail_seen, 0);
      check("rst_ffi", first_fail_idx, 0);

      // 1: golden function
      load_mask(16'h1F55);
      mode = 0;
      kick();
      check("c1_busy", busy, 1);
      check("c1_stim0", stim, 0);
      tick();
      check("c1_stim_hold", stim, 0);
      tick();
      check("c1_stim1", stim, 1);
      wait_done(n);
      check("c1_lat", n + 2, 32);
      check("c1_pass", pass, 1);
      check("c1_mm", mismatch_cnt, 0);
      check("c1_ones", ones_cnt, 9);
      check("c1_fseen", fail_seen, 0);
      check("c1_busy_end", busy, 0);
      check("c1_stim_end", stim, 0);
      tick();
      check("c1_done_drop", done, 0);
      check("c1_pass_hold", pass, 1);

      // 2: stuck-at-0 output
      mode = 1;
      kick();
      check("c2_pass_clr", pass, 0);
      wait_done(n);
      check("c2_lat", n, 32);
      check("c2_mm", mismatch_cnt, 9);
      check("c2_ffi", first_fail_idx, 0);
      check("c2_fseen", fail_seen, 1);
      check("c2_pass", pass, 0);
      check("c2_ones", ones_cnt, 0);
      tick();

      // 3: single inverted minterm
      mode = 2;
      kick();
      check("c3_fseen_clr", fail_seen, 0);
      wait_done(n);
      check("c3_mm", mismatch_cnt, 1);
      check("c3_ffi", first_fail_idx, 5);
      check("c3_fseen", fail_seen, 1);
      check("c3_ones", ones_cnt, 10);
      check("c3_pass", pass, 0);
      tick();

      // 4: reset mid-sweep
      mode = 0;
      kick();
      for (int i = 0; i < 10; i++) tick();
      check("c4_busy_pre", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("c4_busy", busy, 0);
      check("c4_stim", stim, 0);
      check("c4_mm", mismatch_cnt, 0);
      check("c4_ones", ones_cnt, 0);
      check("c4_fseen", fail_seen, 0);
      check("c4_ffi", first_fail_idx, 0);
      check("c4_pass", pass, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      check("c4_no_done", seen, 0);
      load_mask(16'h1F55);
      kick();
      wait_done(n);
      check("c4_lat", n, 32);
      check("c4_pass2", pass, 1);
      check("c4_ones2", ones_cnt, 9);
      tick();

      // 5: start/cfg while busy, start on done cycle
      kick();
      for (int i = 0; i < 3; i++) tick();
      start     = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
      tick();
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      wait_done(n);
      check("c5_lat", n + 5, 32);
      check("c5_pass", pass, 1);
      check("c5_mm", mismatch_cnt, 0);
      check("c5_ones", ones_cnt, 9);
      kick();
      check("c5_no_restart", busy, 0);
      check("c5_done_drop", done, 0);
      tick();
      check("c5_idle", busy, 0);
      check("c5_pass_hold", pass, 1);

      // 6: 2-input AND, SETTLE=0
      for (int i = 3; i >= 0; i--) begin
         cfg_valid_b = 1'b1;
         cfg_bit_b   = (i == 3);
         tick();
      end
      cfg_valid_b = 1'b0;
      cfg_bit_b   = 1'b0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("c6_stim", stim_b, k);
         check("c6_busy", busy_b, 1);
         tick();
      end
      check("c6_done", done_b, 1);
      check("c6_pass", pass_b, 1);
      check("c6_ones", ones_cnt_b, 1);
      check("c6_mm", mismatch_cnt_b, 0);
      tick();
      check("c6_done_drop", done_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
